debug_hex_input: RTL
====================

# debug_hex_input

Front-panel entry block for the debug unit: debounces three raw push-buttons and builds a 32-bit hex value, one 4-bit switch digit at a time. It is the input counterpart of the seven-segment display path. `data_entry` drives the display while the user edits, and `data_out` / `data_valid` deliver the committed value to the CPU debug logic (memory address, register index, breakpoint). The block runs on the board clock and uses no other clocks.

## Interface
- `WIDTH`, 32: entry/output width; must be a multiple of 4.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a button change; 10 ms at 100 MHz. Benches use 4.
- `CNT_W`, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk`  input  1  board clock.
- `rst`  input  1  synchronous, active-high reset.
- `sw_hex`  input  4  hex digit from switches; sampled on the add event.
- `btn_add`  input  1  raw, asynchronous button: append digit.
- `btn_del`  input  1  raw, asynchronous button: delete last digit.
- `btn_enter`  input  1  raw, asynchronous button: commit value.
- `data_entry`  output  WIDTH  value being edited.
- `data_out`  output  WIDTH  last committed value.
- `data_valid`  output  1  one-cycle pulse on commit.
- `digit_cnt`  output  4  digits entered, 0..WIDTH/4, saturating.

## Operation
- Each button has its own chain:
  - 2-flop synchronizer (`s1`, `s2`).
  - Debouncer: a `stable` flop plus a CNT_W-bit counter.
    - Counter clears whenever `s2 == stable`.
    - Otherwise the counter increments.
    - When `s2 != stable` and the counter equals DEBOUNCE_CYCLES-1, `stable` takes `s2` and the counter clears.
  - Rising-edge detector: a one-cycle registered event `ev` fires when `stable` goes 0→1.
  - Releases are debounced the same way and produce no event.
- Event handling, one action per cycle, priority enter > del > add. Lower-priority events in the same cycle are dropped.
  - Enter:
    - `data_out` <= `data_entry`.
    - `data_valid` <= 1 for exactly one cycle.
    - `data_entry` <= 0 and `digit_cnt` <= 0.
  - Del: `data_entry` <= `data_entry >> 4`; `digit_cnt` decrements. At `digit_cnt` = 0, nothing changes.
  - Add: `data_entry` <= `{data_entry[WIDTH-5:0], sw_hex}`; `digit_cnt` increments and saturates at WIDTH/4. When full, the most-significant digit is discarded.
- `sw_hex` is taken as-is at the event cycle; it is not synchronized or debounced. The user sets the switches before pressing.
- `data_out` holds its value until the next enter.
- Entering an empty value (`digit_cnt` = 0) commits 0 and still pulses `data_valid`.

## Timing
- Reset, at the clock edge where `rst` = 1:
  - `data_entry`, `data_out`, `data_valid`, `digit_cnt` all 0.
  - All synchronizers, `stable` flops, counters and `ev` cleared.
  - Any in-progress debounce is abandoned.
- Latency, with edge 0 being the first edge sampling a raw button high and the button held clean:
  - `s2` is high after edge 1.
  - `stable` rises at edge DEBOUNCE_CYCLES+1.
  - `ev` is high after edge DEBOUNCE_CYCLES+2.
  - `data_entry` / `data_out` / `data_valid` update at edge DEBOUNCE_CYCLES+3.
- Any bounce (`s2` returning to `stable`) restarts the count. A pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- Holding a button produces exactly one event. A new event needs a debounced release, then a debounced press.
- A button held through reset release is treated as a new press: one event after the full latency.
- Simultaneous debounced edges on different buttons resolve by priority in the same cycle.

## Test plan
1. Reset, DEBOUNCE_CYCLES=4: assert `rst` mid-debounce of `btn_add` → all outputs 0 next edge; the press produces no event unless held 4 more cycles after release of `rst`.
2. Entry:
   - `sw_hex` = 0xA, then 0x5, then 0xF, each with a clean add press → `data_entry` = 0x00000A5F, `digit_cnt` = 3.
   - Each update lands exactly 7 edges (DEBOUNCE_CYCLES+3) after the raw press.
3. Bounce: `btn_add` toggling 1,0,1,1,0 cycle-by-cycle, then held 10 cycles → exactly one append; a 3-cycle pulse → no append.
4. Overflow/underflow:
   - 9 adds of 0x1..0x9 → `data_entry` = 0x23456789, `digit_cnt` = 8.
   - 9 dels → `data_entry` = 0, `digit_cnt` = 0, unchanged on the ninth.
5. Commit:
   - Entry 0x1234, enter → `data_out` = 0x1234.
   - `data_valid` high for one cycle; `data_entry` = 0, `digit_cnt` = 0.
   - Holding enter 50 cycles yields no second pulse.
6. Simultaneous events: `btn_add` and `btn_enter` pressed on the same edge with entry 0x7 → `data_out` = 0x7, the add is dropped, `data_entry` = 0.

Source files
------------

// File: rtl/debug_hex_input.sv
// Front-panel hex entry: debounces add/del/enter buttons and
// assembles a WIDTH-bit value one switch digit at a time.
module debug_hex_input #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       sw_hex,
    input  logic             btn_add,
    input  logic             btn_del,
    input  logic             btn_enter,
    output logic [WIDTH-1:0] data_entry,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [3:0]       digit_cnt
);

    localparam int NB = 3;
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] MAX_DIGITS = 4'(WIDTH / 4);

    // Bit order everywhere: 0 = add, 1 = del, 2 = enter.
    logic [NB-1:0]    raw;
    logic [NB-1:0]    s1;
    logic [NB-1:0]    s2;
    logic [NB-1:0]    stable;
    logic [NB-1:0]    stable_q;
    logic [NB-1:0]    ev;
    logic [CNT_W-1:0] cnt [NB];

    logic [WIDTH-1:0] entry_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             valid_nxt;
    logic [3:0]       cnt_nxt;

    assign raw = {btn_enter, btn_del, btn_add};

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce: accept s2 only after it differs from stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Registered rising-edge event on the debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            ev       <= '0;
        end else begin
            stable_q <= stable;
            ev       <= stable & ~stable_q;
        end
    end

    // One action per cycle; enter beats del beats add.
    always_comb begin
        entry_nxt = data_entry;
        out_nxt   = data_out;
        valid_nxt = 1'b0;
        cnt_nxt   = digit_cnt;
        if (ev[2]) begin
            out_nxt   = data_entry;
            valid_nxt = 1'b1;
            entry_nxt = '0;
            cnt_nxt   = '0;
        end else if (ev[1]) begin
            if (digit_cnt != 4'd0) begin
                entry_nxt = data_entry >> 4;
                cnt_nxt   = digit_cnt - 4'd1;
            end
        end else if (ev[0]) begin
            entry_nxt = {data_entry[WIDTH-5:0], sw_hex};
            if (digit_cnt != MAX_DIGITS) begin
                cnt_nxt = digit_cnt + 4'd1;
            end
        end
    end

    // Entry, committed value and commit pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_entry <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            digit_cnt  <= '0;
        end else begin
            data_entry <= entry_nxt;
            data_out   <= out_nxt;
            data_valid <= valid_nxt;
            digit_cnt  <= cnt_nxt;
        end
    end

endmodule
